// File: rtl/tx_rd_req_sched.sv
// tx_rd_req_sched: splits one huge-page descriptor into 4 KB-safe read chunks,
// tracks their tags until all completions drain, then requests the completion write.
module tx_rd_req_sched #(
    parameter int MAX_RD_QW       = 64,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic        trn_clk,
    input  logic        reset_n,
    input  logic        hp_valid,
    input  logic [63:0] hp_addr,
    input  logic [18:0] hp_len_qw,
    output logic        hp_ack,
    output logic [63:0] huge_page_addr,
    output logic [8:0]  qwords_to_rd,
    output logic        read_chunk,
    input  logic        read_chunk_ack,
    input  logic [3:0]  tlp_tag,
    input  logic        cpl_done,
    input  logic [3:0]  cpl_done_tag,
    output logic        send_rd_completed,
    input  logic        send_rd_completed_ack,
    output logic        hp_done,
    output logic [4:0]  outstanding,
    output logic        busy,
    output logic        tag_err
);
    typedef enum logic [2:0] {IDLE, CALC, ISSUE, DRAIN, REPORT, DONE} state_t;
    localparam logic [9:0] L_MAX = 10'(MAX_RD_QW);
    localparam logic [4:0] L_OUT = 5'(MAX_OUTSTANDING);
    state_t      r_state, w_state_nxt;
    logic [63:0] r_cur_addr, r_addr;
    logic [18:0] r_rem;
    logic [8:0]  r_qwords, w_qw;
    logic [9:0]  w_bound, w_lim;
    logic [15:0] r_bitmap, w_bitmap_nxt, w_set, w_clr;
    logic [4:0]  r_outstanding;
    logic        r_hp_done, r_tag_err, w_read_chunk, w_acc, w_last;
    always_comb begin
        w_bound      = 10'd512 - {1'b0, r_cur_addr[11:3]};
        w_lim        = (L_MAX < w_bound) ? L_MAX : w_bound;
        w_qw         = (r_rem < {9'd0, w_lim}) ? r_rem[8:0] : w_lim[8:0];
        w_read_chunk = (r_state == ISSUE) && (r_outstanding < L_OUT) && !r_bitmap[tlp_tag];
        w_acc        = w_read_chunk && read_chunk_ack;
        w_last       = r_rem == {10'd0, r_qwords};
        w_set        = w_acc ? 16'd1 << tlp_tag : 16'd0;
        // a completion only retires a tag that is actually in flight
        w_clr        = (cpl_done && r_bitmap[cpl_done_tag]) ? 16'd1 << cpl_done_tag : 16'd0;
        w_bitmap_nxt = (r_bitmap & ~w_clr) | w_set;
    end
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    w_state_nxt = hp_valid ? ((hp_len_qw == 19'd0) ? DONE : CALC) : IDLE;
            CALC:    w_state_nxt = ISSUE;
            ISSUE:   w_state_nxt = w_acc ? (w_last ? DRAIN : CALC) : ISSUE;
            DRAIN:   w_state_nxt = (r_outstanding == 5'd0) ? REPORT : DRAIN;
            REPORT:  w_state_nxt = send_rd_completed_ack ? DONE : REPORT;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge trn_clk) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end
    always_ff @(posedge trn_clk) begin
        if (!reset_n) begin
            r_cur_addr    <= '0;
            r_rem         <= '0;
            r_addr        <= '0;
            r_qwords      <= '0;
            r_bitmap      <= '0;
            r_outstanding <= '0;
            r_hp_done     <= 1'b0;
            r_tag_err     <= 1'b0;
        end else begin
            if (r_state == IDLE && hp_valid) begin
                r_cur_addr <= hp_addr & ~64'd7;
                r_rem      <= hp_len_qw;
            end
            if (r_state == CALC) begin
                r_addr   <= r_cur_addr;
                r_qwords <= w_qw;
            end
            if (w_acc) begin
                r_cur_addr <= r_cur_addr + {52'd0, r_qwords, 3'b000};
                r_rem      <= r_rem - {10'd0, r_qwords};
            end
            r_bitmap      <= w_bitmap_nxt;
            r_outstanding <= 5'($countones(w_bitmap_nxt));
            r_hp_done     <= r_state == DONE;
            r_tag_err     <= r_tag_err | (cpl_done && !r_bitmap[cpl_done_tag]);
        end
    end
    assign hp_ack            = reset_n && (r_state == IDLE) && hp_valid;
    assign huge_page_addr    = r_addr;
    assign qwords_to_rd      = r_qwords;
    assign read_chunk        = w_read_chunk;
    assign send_rd_completed = r_state == REPORT;
    assign hp_done           = r_hp_done;
    assign outstanding       = r_outstanding;
    assign busy              = r_state != IDLE;
    assign tag_err           = r_tag_err;
endmodule

// File: tb/tb_tx_rd_req_sched.sv
// tb_tx_rd_req_sched: directed scenarios with a chunk scoreboard filled from a reference splitter.
module tb_tx_rd_req_sched;
    logic        trn_clk = 1'b0;
    logic        reset_n, hp_valid, hp_ack, read_chunk, read_chunk_ack, cpl_done;
    logic        send_rd_completed, send_rd_completed_ack, hp_done, busy, tag_err;
    logic [63:0] hp_addr, huge_page_addr;
    logic [18:0] hp_len_qw;
    logic [8:0]  qwords_to_rd;
    logic [3:0]  tlp_tag, cpl_done_tag;
    logic [4:0]  outstanding;
    typedef struct {logic [63:0] a; logic [8:0] q;} chunk_t;
    chunk_t sb[$];
    int checks = 0, errors = 0;

    tx_rd_req_sched #(.MAX_RD_QW(64), .MAX_OUTSTANDING(2)) dut (
        .trn_clk(trn_clk), .reset_n(reset_n), .hp_valid(hp_valid), .hp_addr(hp_addr),
        .hp_len_qw(hp_len_qw), .hp_ack(hp_ack), .huge_page_addr(huge_page_addr),
        .qwords_to_rd(qwords_to_rd), .read_chunk(read_chunk), .read_chunk_ack(read_chunk_ack),
        .tlp_tag(tlp_tag), .cpl_done(cpl_done), .cpl_done_tag(cpl_done_tag),
        .send_rd_completed(send_rd_completed), .send_rd_completed_ack(send_rd_completed_ack),
        .hp_done(hp_done), .outstanding(outstanding), .busy(busy), .tag_err(tag_err));

    always #5 trn_clk = ~trn_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge trn_clk);
        #1;
    endtask

    task automatic model(input logic [63:0] addr, input int len);
        logic [63:0] a;
        int rem, bound, q;
        a = addr & ~64'd7;
        rem = len;
        while (rem > 0) begin
            bound = 512 - int'(a[11:3]);
            q = rem < 64 ? rem : 64;
            q = q < bound ? q : bound;
            sb.push_back('{a: a, q: 9'(q)});
            a = a + 64'(q * 8);
            rem = rem - q;
        end
    endtask

    task automatic start(input logic [63:0] addr, input logic [18:0] len);
        hp_addr = addr;
        hp_len_qw = len;
        hp_valid = 1'b1;
        model(addr, int'(len));
        #1;
        chk("hp_ack", hp_ack, 1);
        tick();
        hp_valid = 1'b0;
        chk("busy_after_accept", busy, 1);
    endtask

    task automatic take(input logic [3:0] tag);
        chunk_t e;
        int n = 0;
        tlp_tag = tag;
        #1;
        while (!read_chunk && n < 20) begin
            tick();
            #1;
            n++;
        end
        chk("read_chunk_wait", read_chunk, 1);
        if (read_chunk) begin
            if (sb.size() == 0) chk("sb_underflow", 1, 0);
            else begin
                e = sb.pop_front();
                chk("chunk_addr", huge_page_addr, e.a);
                chk("chunk_qw", 64'(qwords_to_rd), 64'(e.q));
            end
            read_chunk_ack = 1'b1;
            tick();
            read_chunk_ack = 1'b0;
            #1;
            chk("read_chunk_drop", read_chunk, 0);
        end
    endtask

    task automatic cpl(input logic [3:0] tag);
        cpl_done = 1'b1;
        cpl_done_tag = tag;
        tick();
        cpl_done = 1'b0;
    endtask

    task automatic finish_desc();
        int n = 0;
        while (!send_rd_completed && n < 20) begin
            tick();
            n++;
        end
        chk("send_rd_completed_wait", send_rd_completed, 1);
        send_rd_completed_ack = 1'b1;
        tick();
        send_rd_completed_ack = 1'b0;
        chk("send_drop", send_rd_completed, 0);
        chk("hp_done_early", hp_done, 0);
        tick();
        chk("hp_done_pulse", hp_done, 1);
        tick();
        chk("hp_done_end", hp_done, 0);
        chk("idle_after_done", busy, 0);
    endtask

    initial begin
        reset_n = 1'b0; hp_valid = 1'b0; hp_addr = '0; hp_len_qw = '0;
        read_chunk_ack = 1'b0; tlp_tag = '0; cpl_done = 1'b0; cpl_done_tag = '0;
        send_rd_completed_ack = 1'b0;
        tick(); tick();
        chk("rst_busy", busy, 0);
        chk("rst_outstanding", outstanding, 0);
        chk("rst_read_chunk", read_chunk, 0);
        chk("rst_addr", huge_page_addr, 0);
        chk("rst_qw", qwords_to_rd, 0);
        chk("rst_tag_err", tag_err, 0);
        chk("rst_send", send_rd_completed, 0);
        reset_n = 1'b1;
        tick();

        // aligned 256 qw, two-credit stall in the middle
        start(64'h1_0000_0000, 19'd256);
        take(4'd0);
        take(4'd1);
        tlp_tag = 4'd2;
        tick(); tick();
        chk("stall_read_chunk", read_chunk, 0);
        chk("stall_outstanding", outstanding, 2);
        cpl(4'd0);
        chk("credit_reassert", read_chunk, 1);
        take(4'd2);
        cpl(4'd1);
        take(4'd1);
        read_chunk_ack = 1'b1;
        tlp_tag = 4'd5;
        tick();
        read_chunk_ack = 1'b0;
        chk("stray_ack_ignored", outstanding, 2);
        chk("drain_no_send", send_rd_completed, 0);
        cpl(4'd1);
        cpl(4'd2);
        finish_desc();
        chk("sb_empty_1", sb.size(), 0);

        // 4 KB crossing with a tag collision on the second chunk
        start(64'h0FF0, 19'd10);
        take(4'd3);
        tlp_tag = 4'd3;
        tick(); tick();
        chk("collision_stall", read_chunk, 0);
        chk("collision_outstanding", outstanding, 1);
        cpl(4'd3);
        chk("collision_release", read_chunk, 1);
        take(4'd3);
        cpl(4'd3);
        finish_desc();
        chk("sb_empty_2", sb.size(), 0);

        // zero length: straight to DONE
        start(64'h1234, 19'd0);
        chk("zero_hp_done_1", hp_done, 0);
        chk("zero_read_chunk", read_chunk, 0);
        tick();
        chk("zero_hp_done_2", hp_done, 1);
        chk("zero_send", send_rd_completed, 0);
        tick();
        chk("zero_hp_done_end", hp_done, 0);

        // stray completion, then reset while draining
        cpl(4'd9);
        chk("tag_err_set", tag_err, 1);
        tick(); tick();
        chk("tag_err_sticky", tag_err, 1);
        start(64'h2000, 19'd64);
        take(4'd4);
        chk("drain_busy", busy, 1);
        chk("drain_outstanding", outstanding, 1);
        reset_n = 1'b0;
        tick();
        chk("rst2_busy", busy, 0);
        chk("rst2_outstanding", outstanding, 0);
        chk("rst2_tag_err", tag_err, 0);
        chk("rst2_addr", huge_page_addr, 0);
        chk("rst2_qw", qwords_to_rd, 0);
        reset_n = 1'b1;
        tick();

        // tag 4 must be free again after reset
        start(64'h3008, 19'd8);
        take(4'd4);
        cpl(4'd4);
        finish_desc();
        chk("sb_empty_3", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
